// File: rtl/udp_tx_buf_pkg.sv
// Shared types and constants for the UDP transmit packet buffer.
package udp_tx_buf_pkg;

  // Read-side burst sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StGap
  } rd_state_e;

  // Shortest UDP payload reported when minimum-frame padding is enabled.
  localparam int unsigned C_MIN_UDP_LEN = 18;

  // Address width needed to index a power-of-2 depth (at least 1 bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/udp_tx_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module udp_tx_sdp_ram #(
  parameter int unsigned Depth = 2048,
  parameter int unsigned AddrW = 11,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port with one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_tx_packet_buffer.sv
// Store-and-forward frame buffer in front of the UDP stack send port.
// Frames are committed on their last byte and replayed as one gap-free burst
// with the length valid from the first byte. Oversize frames are dropped.
// Optional feature: define UDP_TX_PAD_EN to pad short frames to 18 bytes.
module udp_tx_packet_buffer
  import udp_tx_buf_pkg::*;
#(
  parameter int unsigned P_DATA_DEPTH = 2048,
  parameter int unsigned P_LEN_DEPTH  = 16,
  parameter int unsigned P_MAX_LEN    = 1472,
  parameter int unsigned P_IFG        = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_user_data,
  input  logic        i_user_valid,
  input  logic        i_user_last,
  output logic        o_user_ready,
  output logic [7:0]  o_send_udp_data,
  output logic [15:0] o_send_udp_len,
  output logic        o_send_udp_last,
  output logic        o_send_udp_valid,
  input  logic        i_send_ready,
  output logic        o_frame_drop,
  output logic [7:0]  o_frame_count
);

  localparam int unsigned AW = ptr_w(P_DATA_DEPTH);
  localparam int unsigned LW = ptr_w(P_LEN_DEPTH);
  localparam logic [15:0] MaxLen  = 16'(P_MAX_LEN);
  localparam logic [15:0] IfgLast = 16'(P_IFG - 1);
  localparam logic [LW:0] LenFull = (LW + 1)'(P_LEN_DEPTH);

  // Write side state.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   commit_ptr_q, commit_ptr_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic          discard_q, discard_d;
  logic          drop_q, drop_d;

  // Length FIFO.
  logic [15:0]   len_mem_q [P_LEN_DEPTH];
  logic [LW-1:0] len_wr_q, len_wr_d;
  logic [LW-1:0] len_rd_q, len_rd_d;
  logic [LW:0]   len_cnt_q, len_cnt_d;
  logic          len_push, len_pop;

  // Read side state.
  rd_state_e     state_q, state_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]   send_len_q, send_len_d;
  logic [15:0]   frame_len_q, frame_len_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]    frame_count_q, frame_count_d;

  logic          data_full, len_full, len_empty, accept;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic          send_valid, send_last, pad_byte;
  logic [15:0]   len_head;

  // Extra pointer bit distinguishes full from empty.
  assign data_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign len_full  = (len_cnt_q == LenFull);
  assign len_empty = (len_cnt_q == '0);
  assign o_user_ready = !data_full && !len_full;
  assign accept = i_user_valid && o_user_ready;
  assign len_head = len_mem_q[len_rd_q];

  // Write path: store, commit on last, rewind and discard on oversize.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    discard_d    = discard_q;
    drop_d       = 1'b0;
    ram_we       = 1'b0;
    len_push     = 1'b0;
    if (accept) begin
      if (discard_q) begin
        if (i_user_last) begin
          discard_d = 1'b0;
        end
      end else if (wr_cnt_q == MaxLen) begin
        wr_ptr_d  = commit_ptr_q;
        wr_cnt_d  = '0;
        drop_d    = 1'b1;
        discard_d = !i_user_last;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_user_last) begin
          len_push     = 1'b1;
          commit_ptr_d = wr_ptr_q + 1'b1;
          wr_cnt_d     = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
    end
  end

  // Read sequencer: load length, stream bytes with prefetch, then idle gap.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    send_len_d  = send_len_q;
    frame_len_d = frame_len_q;
    gap_cnt_d   = gap_cnt_q;
    len_pop     = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = rd_ptr_q[AW-1:0];
    send_valid  = 1'b0;
    send_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!len_empty && i_send_ready) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        len_pop     = 1'b1;
        frame_len_d = len_head;
`ifdef UDP_TX_PAD_EN
        send_len_d  = (len_head < 16'(C_MIN_UDP_LEN)) ? 16'(C_MIN_UDP_LEN) : len_head;
`else
        send_len_d  = len_head;
`endif
        byte_cnt_d  = '0;
        ram_re      = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        send_valid = 1'b1;
        send_last  = (byte_cnt_q == send_len_q - 16'd1);
        // Fetch the byte after the one currently on the output.
        ram_re     = 1'b1;
        ram_raddr  = rd_ptr_q[AW-1:0] + AW'(byte_cnt_q) + AW'(1);
        if (send_last) begin
          rd_ptr_d   = rd_ptr_q + (AW + 1)'(frame_len_q);
          send_len_d = '0;
          gap_cnt_d  = '0;
          state_d    = StGap;
        end else begin
          byte_cnt_d = byte_cnt_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == IfgLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Length FIFO pointers and occupancy; push and pop may coincide.
  always_comb begin
    len_wr_d  = len_push ? len_wr_q + 1'b1 : len_wr_q;
    len_rd_d  = len_pop ? len_rd_q + 1'b1 : len_rd_q;
    len_cnt_d = len_cnt_q;
    unique case ({len_push, len_pop})
      2'b10:   len_cnt_d = len_cnt_q + 1'b1;
      2'b01:   len_cnt_d = len_cnt_q - 1'b1;
      default: len_cnt_d = len_cnt_q;
    endcase
  end

  // Pending-frame counter, saturating at both ends.
  always_comb begin
    frame_count_d = frame_count_q;
    unique case ({len_push, send_last})
      2'b10:   if (frame_count_q != 8'hff) frame_count_d = frame_count_q + 8'd1;
      2'b01:   if (frame_count_q != 8'h00) frame_count_d = frame_count_q - 8'd1;
      default: frame_count_d = frame_count_q;
    endcase
  end

  // Pad bytes beyond the stored length read as zero.
  always_comb begin
`ifdef UDP_TX_PAD_EN
    pad_byte = (byte_cnt_q >= frame_len_q);
`else
    pad_byte = 1'b0;
`endif
    o_send_udp_data = (send_valid && !pad_byte) ? ram_rdata : 8'h00;
  end

  assign o_send_udp_valid = send_valid;
  assign o_send_udp_last  = send_last;
  assign o_send_udp_len   = send_len_q;
  assign o_frame_drop     = drop_q;
  assign o_frame_count    = frame_count_q;

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      wr_cnt_q      <= '0;
      discard_q     <= 1'b0;
      drop_q        <= 1'b0;
      len_wr_q      <= '0;
      len_rd_q      <= '0;
      len_cnt_q     <= '0;
      state_q       <= StIdle;
      rd_ptr_q      <= '0;
      byte_cnt_q    <= '0;
      send_len_q    <= '0;
      frame_len_q   <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      wr_cnt_q      <= wr_cnt_d;
      discard_q     <= discard_d;
      drop_q        <= drop_d;
      len_wr_q      <= len_wr_d;
      len_rd_q      <= len_rd_d;
      len_cnt_q     <= len_cnt_d;
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      send_len_q    <= send_len_d;
      frame_len_q   <= frame_len_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Length FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge i_clk) begin
    if (len_push) begin
      len_mem_q[len_wr_q] <= wr_cnt_q + 16'd1;
    end
  end

  udp_tx_sdp_ram #(
    .Depth (P_DATA_DEPTH),
    .AddrW (AW),
    .Width (8)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (i_user_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_udp_tx_packet_buffer.sv
// Self-checking bench for udp_tx_packet_buffer with a frame-level reference model.
module tb_udp_tx_packet_buffer;

  localparam int P_MAX_LEN = 1472;
  localparam int P_IFG     = 12;
  localparam int MIN_LEN   = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  user_data;
  logic        user_valid, user_last, send_ready;
  logic        o_user_ready, o_send_udp_last, o_send_udp_valid, o_frame_drop;
  logic [7:0]  o_send_udp_data, o_frame_count;
  logic [15:0] o_send_udp_len;

  always #5 clk = ~clk;

  udp_tx_packet_buffer #(
    .P_DATA_DEPTH (2048),
    .P_LEN_DEPTH  (16),
    .P_MAX_LEN    (P_MAX_LEN),
    .P_IFG        (P_IFG)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_user_data      (user_data),
    .i_user_valid     (user_valid),
    .i_user_last      (user_last),
    .o_user_ready     (o_user_ready),
    .o_send_udp_data  (o_send_udp_data),
    .o_send_udp_len   (o_send_udp_len),
    .o_send_udp_last  (o_send_udp_last),
    .o_send_udp_valid (o_send_udp_valid),
    .i_send_ready     (send_ready),
    .o_frame_drop     (o_frame_drop),
    .o_frame_count    (o_frame_count)
  );

  int checks = 0, passes = 0, fails = 0, timeouts = 0;

  // Reference model: expected reported lengths and byte stream.
  int         exp_len[$];
  logic [7:0] exp_bytes[$];
  int         exp_drops = 0;

  // Observed bursts.
  int         rx_len[$], rx_n[$], rx_gap[$];
  logic       rx_ok[$];
  logic [7:0] rx_bytes[$];
  logic [7:0] cur_q[$];
  logic [15:0] cur_len;
  logic       cur_ok, in_burst = 1'b0;
  int         idle_run = 1000, drop_cnt = 0, vcnt = 0;
  int         saved_v, saved_rx, saved_drops, drop_pos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (o_frame_drop === 1'b1) drop_cnt++;
      if (o_send_udp_valid === 1'b1) begin
        vcnt++;
        if (!in_burst) begin
          in_burst = 1'b1;
          cur_len  = o_send_udp_len;
          cur_ok   = 1'b1;
          cur_q.delete();
          rx_gap.push_back(idle_run);
        end
        if (o_send_udp_len !== cur_len) cur_ok = 1'b0;
        cur_q.push_back(o_send_udp_data);
        idle_run = 0;
        if (o_send_udp_last === 1'b1) begin
          rx_len.push_back(int'(cur_len));
          rx_n.push_back(cur_q.size());
          rx_ok.push_back(cur_ok);
          foreach (cur_q[i]) rx_bytes.push_back(cur_q[i]);
          in_burst = 1'b0;
        end
      end else begin
        if (in_burst) cur_ok = 1'b0;
        idle_run++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_commit(input logic [7:0] q[$]);
    int el;
    el = q.size();
`ifdef UDP_TX_PAD_EN
    if (el < MIN_LEN) el = MIN_LEN;
`endif
    exp_len.push_back(el);
    for (int i = 0; i < el; i++) exp_bytes.push_back((i < q.size()) ? q[i] : 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int budget;
    budget = 5000;
    @(negedge clk);
    user_data = d; user_valid = 1'b1; user_last = l;
    while (!o_user_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) timeouts++;
  endtask

  task automatic send_frame(input int n, input int max_idle, input bit incr);
    logic [7:0] q[$];
    logic [7:0] d;
    int k;
    for (int i = 0; i < n; i++) begin
      d = incr ? 8'(i) : 8'($urandom);
      q.push_back(d);
      push_byte(d, i == n - 1);
      if (max_idle > 0 && i != n - 1) begin
        k = $urandom_range(max_idle, 0);
        repeat (k) begin
          @(negedge clk);
          user_valid = 1'b0; user_last = 1'b0;
        end
      end
    end
    @(negedge clk);
    user_valid = 1'b0; user_last = 1'b0;
    if (n <= P_MAX_LEN) model_commit(q);
    else exp_drops++;
  endtask

  task automatic wait_valid();
    int budget;
    budget = 3000;
    while (o_send_udp_valid !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) timeouts++;
  endtask

  task automatic wait_rx(input int n);
    int budget;
    budget = 6000;
    while (rx_len.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
  endtask

  task automatic check_bursts(input string tag);
    int el, rl, n, g, bad;
    logic ok;
    logic [7:0] eb, rb;
    wait_rx(exp_len.size());
    chk({tag, "_bursts"}, rx_len.size(), exp_len.size());
    while (exp_len.size() > 0 && rx_len.size() > 0) begin
      el = exp_len.pop_front();
      rl = rx_len.pop_front();
      n  = rx_n.pop_front();
      g  = rx_gap.pop_front();
      ok = rx_ok.pop_front();
      chk({tag, "_len"}, rl, el);
      chk({tag, "_nbytes"}, n, el);
      chk({tag, "_contig"}, {31'd0, ok}, 1);
      chk({tag, "_gap"}, {31'd0, (g >= P_IFG)}, 1);
      bad = 0;
      for (int i = 0; i < el || i < n; i++) begin
        eb = 8'hxx; rb = 8'hzz;
        if (i < el && exp_bytes.size() > 0) eb = exp_bytes.pop_front();
        if (i < n && rx_bytes.size() > 0) rb = rx_bytes.pop_front();
        if (rb !== eb) bad++;
      end
      chk({tag, "_data"}, bad, 0);
    end
    exp_len.delete(); exp_bytes.delete();
    rx_len.delete(); rx_n.delete(); rx_gap.delete(); rx_ok.delete(); rx_bytes.delete();
  endtask

  initial begin
    rst = 1'b1; user_data = '0; user_valid = 1'b0; user_last = 1'b0; send_ready = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state.
    chk("rst_valid", o_send_udp_valid, 0);
    chk("rst_len", o_send_udp_len, 0);
    chk("rst_count", o_frame_count, 0);
    chk("rst_ready", o_user_ready, 1);
    rst = 1'b0;

    // 1: single 64-byte incrementing frame.
    send_ready = 1'b1;
    send_frame(64, 0, 1'b1);
    check_bursts("t1");

    // 2: 10, 1, 300 byte frames held back, then released.
    send_ready = 1'b0;
    send_frame(10, 0, 1'b0);
    send_frame(1, 0, 1'b0);
    send_frame(300, 0, 1'b0);
    chk("t2_count_peak", o_frame_count, 3);
    send_ready = 1'b1;
    check_bursts("t2");
    repeat (3) @(negedge clk);
    chk("t2_count_zero", o_frame_count, 0);

    // 3: oversize frame dropped, following frame intact.
    saved_drops = drop_cnt;
    send_frame(1500, 0, 1'b0);
    send_frame(20, 0, 1'b0);
    check_bursts("t3");
    chk("t3_drops", drop_cnt - saved_drops, 1);

    // 4: fill the length FIFO while the stack is not ready.
    send_ready = 1'b0;
    repeat (20) @(negedge clk);
    for (int f = 0; f < 16; f++) send_frame(8, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_ready_full", o_user_ready, 0);
    chk("t4_count", o_frame_count, 16);
    send_ready = 1'b1;
    check_bursts("t4");
    chk("t4_ready_after", o_user_ready, 1);

    // 5a: ready dropped mid-burst does not break the burst.
    send_frame(100, 0, 1'b0);
    wait_valid();
    repeat (10) @(negedge clk);
    send_ready = 1'b0;
    repeat (30) @(negedge clk);
    send_ready = 1'b1;
    check_bursts("t5a");

    // 5b: reset mid-burst.
    send_frame(300, 0, 1'b0);
    wait_valid();
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5b_valid", o_send_udp_valid, 0);
    chk("t5b_len", o_send_udp_len, 0);
    chk("t5b_data", o_send_udp_data, 0);
    chk("t5b_last", o_send_udp_last, 0);
    chk("t5b_count", o_frame_count, 0);
    rst = 1'b0;
    in_burst = 1'b0;
    exp_len.delete(); exp_bytes.delete();
    saved_v = vcnt;
    saved_rx = rx_len.size();
    repeat (100) @(negedge clk);
    chk("t5b_no_stale", vcnt - saved_v, 0);
    chk("t5b_no_burst", rx_len.size() - saved_rx, 0);
    send_frame(7, 0, 1'b0);
    check_bursts("t5b_after");

    // 6: short frame, padded or not depending on the build.
    send_frame(5, 0, 1'b0);
    wait_rx(1);
`ifdef UDP_TX_PAD_EN
    chk("t6_len", (rx_len.size() > 0) ? rx_len[0] : -1, MIN_LEN);
`else
    chk("t6_len", (rx_len.size() > 0) ? rx_len[0] : -1, 5);
`endif
    check_bursts("t6");

    // Randomized frames with one oversize frame mixed in.
    saved_drops = drop_cnt;
    exp_drops = 0;
    drop_pos = $urandom_range(7, 0);
    for (int f = 0; f < 8; f++) begin
      if (f == drop_pos) send_frame($urandom_range(1540, P_MAX_LEN + 1), 0, 1'b0);
      send_frame($urandom_range(150, 1), 2, 1'b0);
    end
    check_bursts("rand");
    chk("rand_drops", drop_cnt - saved_drops, exp_drops);
    repeat (3) @(negedge clk);
    chk("rand_count_zero", o_frame_count, 0);

    chk("timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
